reorder_buffer: RTL

- Circular in-order reorder buffer that allocates the 4-bit ROB index carried down the ID/EX stage, and receives out-of-order completions (result and exception code) from the back end.
- Retires one instruction per cycle in program order and raises a precise exception with a full pipeline flush.
- Sits between decode, which allocates, and writeback/commit, which drains it.

---
 rtl/reorder_buffer_pkg.sv | 28 ++
 rtl/reorder_buffer_if.sv | 77 +++++++
 rtl/reorder_buffer_bypass.sv | 33 +++
 rtl/reorder_buffer.sv | 117 +++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// rob_pkg: shared widths, exception codes and ROB entry layout.
// Imported by the ROB interface, top and bypass lookup.
package rob_pkg;
  localparam int ROB_ENTRIES = 16;
  localparam int ROB_IDX_W = 4;
  localparam int XLEN = 32;
  localparam int EXC_W = 3;

  typedef logic [EXC_W-1:0] exc_t;

  localparam exc_t EXC_NONE = 3'd0;
  localparam exc_t EXC_INSN_MISALIGN = 3'd1;
  localparam exc_t EXC_ILLEGAL = 3'd2;
  localparam exc_t EXC_BREAKPOINT = 3'd3;
  localparam exc_t EXC_LOAD_FAULT = 3'd4;
  localparam exc_t EXC_STORE_FAULT = 3'd5;
  localparam exc_t EXC_ECALL = 3'd6;

  typedef struct packed {
    logic valid;
    logic done;
    logic [XLEN-1:0] pc;
    logic [4:0] rd;
    logic we;
    logic [XLEN-1:0] value;
    exc_t exc;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: alloc / complete / commit / exception bundle.
// slave = ROB side, master = pipeline side; ROB_BYPASS_EN adds lookup.
interface reorder_buffer_if;
  import rob_pkg::*;

  logic in_alloc_valid;
  logic [XLEN-1:0] in_alloc_PC;
  logic [4:0] in_alloc_rd;
  logic in_alloc_write_enable;
  logic [ROB_IDX_W-1:0] out_alloc_rob_idx;
  logic out_full;

  logic in_complete_valid;
  logic [ROB_IDX_W-1:0] in_complete_rob_idx;
  logic [XLEN-1:0] in_complete_value;
  logic [EXC_W-1:0] in_complete_exception_vector;

  logic out_commit_valid;
  logic [4:0] out_commit_rd;
  logic [XLEN-1:0] out_commit_value;
  logic out_commit_write_enable;
  logic out_exception_valid;
  logic [XLEN-1:0] out_exception_PC;
  logic [EXC_W-1:0] out_exception_vector;
  logic out_flush;

`ifdef ROB_BYPASS_EN
  logic [4:0] in_lookup_rs1;
  logic [4:0] in_lookup_rs2;
  logic out_rs1_hit;
  logic [XLEN-1:0] out_rs1_value;
  logic out_rs2_hit;
  logic [XLEN-1:0] out_rs2_value;
`endif

  modport slave (
    input in_alloc_valid, in_alloc_PC,
    input in_alloc_rd, in_alloc_write_enable,
    output out_alloc_rob_idx, out_full,
    input in_complete_valid, in_complete_rob_idx,
    input in_complete_value,
    input in_complete_exception_vector,
    output out_commit_valid, out_commit_rd,
    output out_commit_value,
    output out_commit_write_enable,
    output out_exception_valid,
    output out_exception_PC,
    output out_exception_vector,
    output out_flush
`ifdef ROB_BYPASS_EN
    , input in_lookup_rs1, in_lookup_rs2
    , output out_rs1_hit, out_rs1_value
    , output out_rs2_hit, out_rs2_value
`endif
  );

  modport master (
    output in_alloc_valid, in_alloc_PC,
    output in_alloc_rd, in_alloc_write_enable,
    input out_alloc_rob_idx, out_full,
    output in_complete_valid, in_complete_rob_idx,
    output in_complete_value,
    output in_complete_exception_vector,
    input out_commit_valid, out_commit_rd,
    input out_commit_value,
    input out_commit_write_enable,
    input out_exception_valid,
    input out_exception_PC,
    input out_exception_vector,
    input out_flush
`ifdef ROB_BYPASS_EN
    , output in_lookup_rs1, in_lookup_rs2
    , input out_rs1_hit, out_rs1_value
    , input out_rs2_hit, out_rs2_value
`endif
  );
endinterface

// File: rtl/reorder_buffer_bypass.sv
// rob_bypass_lookup: youngest-first rd match over live ROB slots.
// Ports: rob/tail/count state in; rs in; hit/value out.
module rob_bypass_lookup
  import rob_pkg::*;
(
  input rob_entry_t [ROB_ENTRIES-1:0] rob,
  input logic [ROB_IDX_W-1:0] tail,
  input logic [ROB_IDX_W:0] count,
  input logic [4:0] rs,
  output logic hit,
  output logic [XLEN-1:0] value
);
  always_comb begin
    logic found;
    logic [ROB_IDX_W-1:0] idx;
    hit = 1'b0;
    value = '0;
    found = 1'b0;
    idx = '0;
    // k walks from tail-1 back toward head; count bounds the live window
    for (int k = 0; k < ROB_ENTRIES; k++) begin
      idx = tail - ROB_IDX_W'(k + 1);
      if (!found && k < int'(count) && rs != 5'd0
          && rob[idx].valid && rob[idx].we
          && rob[idx].rd == rs) begin
        found = 1'b1;
        // youngest writer still in flight masks older results
        hit = rob[idx].done;
        value = rob[idx].done ? rob[idx].value : '0;
      end
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order ROB, one retire/cycle, precise flush.
// Ports: clk, reset (sync high), rob (reorder_buffer_if.slave); macro ROB_BYPASS_EN.
module reorder_buffer
  import rob_pkg::*;
(
  input logic clk,
  input logic reset,
  reorder_buffer_if.slave rob
);
  localparam int CW = ROB_IDX_W + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(ROB_ENTRIES);

  rob_entry_t [ROB_ENTRIES-1:0] ent_q;
  logic [ROB_IDX_W-1:0] head_q;
  logic [ROB_IDX_W-1:0] tail_q;
  logic [CW-1:0] count_q;

  rob_entry_t head_e;
  logic full;
  logic retire;
  logic exc_ret;
  logic alloc_go;
  logic cmp_go;

  assign head_e = ent_q[head_q];
  assign full = count_q == FULL_CNT;
  assign retire = head_e.valid & head_e.done;
  assign exc_ret = retire & (head_e.exc != EXC_NONE);
  assign alloc_go = rob.in_alloc_valid & ~full & ~exc_ret;
  assign cmp_go = rob.in_complete_valid
                & ent_q[rob.in_complete_rob_idx].valid;

  always_comb begin
    rob.out_alloc_rob_idx = tail_q;
    rob.out_full = full;
    rob.out_commit_valid = retire;
    rob.out_commit_rd = '0;
    rob.out_commit_value = '0;
    rob.out_commit_write_enable = 1'b0;
    rob.out_exception_valid = exc_ret;
    rob.out_exception_PC = '0;
    rob.out_exception_vector = '0;
    rob.out_flush = exc_ret;
    if (retire) begin
      rob.out_commit_rd = head_e.rd;
      rob.out_commit_value = head_e.value;
      rob.out_commit_write_enable = head_e.we & ~exc_ret;
    end
    if (exc_ret) begin
      rob.out_exception_PC = head_e.pc;
      rob.out_exception_vector = head_e.exc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else if (exc_ret) begin
      // precise exception: drop everything younger, restart at slot 0
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        ent_q[i].valid <= 1'b0;
        ent_q[i].done <= 1'b0;
      end
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      if (cmp_go) begin
        ent_q[rob.in_complete_rob_idx].done <= 1'b1;
        ent_q[rob.in_complete_rob_idx].value <= rob.in_complete_value;
        ent_q[rob.in_complete_rob_idx].exc <=
          rob.in_complete_exception_vector;
      end
      if (retire) begin
        ent_q[head_q].valid <= 1'b0;
        ent_q[head_q].done <= 1'b0;
        head_q <= head_q + ROB_IDX_W'(1);
      end
      if (alloc_go) begin
        ent_q[tail_q] <= '{
          valid: 1'b1,
          done: 1'b0,
          pc: rob.in_alloc_PC,
          rd: rob.in_alloc_rd,
          we: rob.in_alloc_write_enable,
          value: '0,
          exc: EXC_NONE
        };
        tail_q <= tail_q + ROB_IDX_W'(1);
      end
      count_q <= count_q + CW'(alloc_go) - CW'(retire);
    end
  end

`ifdef ROB_BYPASS_EN
  rob_bypass_lookup u_rs1 (
    .rob(ent_q),
    .tail(tail_q),
    .count(count_q),
    .rs(rob.in_lookup_rs1),
    .hit(rob.out_rs1_hit),
    .value(rob.out_rs1_value)
  );

  rob_bypass_lookup u_rs2 (
    .rob(ent_q),
    .tail(tail_q),
    .count(count_q),
    .rs(rob.in_lookup_rs2),
    .hit(rob.out_rs2_hit),
    .value(rob.out_rs2_value)
  );
`endif
endmodule
